// File: rtl/lsu_bus_if.sv
// lsu_bus_if: request/response bus between the load/store unit and memory.
`default_nettype none

interface lsu_bus_if;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic        req_we_o;
    logic [31:0] req_wdata_o;
    logic [3:0]  req_strb_o;
    logic        resp_valid_i;
    logic [31:0] resp_data_i;
    logic        resp_err_i;

    modport master (
        output req_valid_o, req_addr_o, req_we_o, req_wdata_o, req_strb_o,
        input  req_ready_i, resp_valid_i, resp_data_i, resp_err_i
    );

    modport slave (
        input  req_valid_o, req_addr_o, req_we_o, req_wdata_o, req_strb_o,
        output req_ready_i, resp_valid_i, resp_data_i, resp_err_i
    );
endinterface

`default_nettype wire

// File: rtl/lsu_bus.sv
// +----------------------------------------------------------------------+
// | lsu_bus : single-outstanding load/store bus master (IDLE/REQ/RESP).   |
// | Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_bus (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_vld_i,
    input  logic [1:0]  op_typ_i,
    input  logic [2:0]  width_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        lsu_bp_o,
    output logic [1:0]  wb_op_typ_o,
    output logic [2:0]  wb_width_o,
    output logic [31:0] wb_addr_o,
    output logic [31:0] lsu_rd_data_o,
    output logic        lsu_exc_o,
    lsu_bus_if.master   bus
);

    localparam logic [1:0] c_OP_NONE  = 2'd0;
    localparam logic [1:0] c_OP_STORE = 2'd2;
    localparam logic [2:0] c_W_H      = 3'd1;
    localparam logic [2:0] c_W_W      = 3'd2;
    localparam logic [2:0] c_W_HU     = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_back;
    logic        w_accept;
    logic        w_bp;
    logic        w_done;
    logic        w_misalign;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;

    logic [1:0]  r_wb_typ;
    logic [2:0]  r_wb_width;
    logic [31:0] r_wb_addr;
    logic [31:0] r_req_addr;
    logic        r_req_we;
    logic [3:0]  r_req_strb;
    logic [31:0] r_req_wdata;
    logic [31:0] r_rdata;
    logic        r_exc;

    assign w_done = (r_state == S_RESP) && bus.resp_valid_i;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = (((width_i == c_W_H) || (width_i == c_W_HU)) && addr_i[0])
                      || ((width_i == c_W_W) && (addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_back blocks acceptance in the first IDLE cycle after a completed response
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_bp        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (op_vld_i && (op_typ_i != c_OP_NONE) && !r_back) begin
                    w_accept = 1'b1;
                    w_bp     = 1'b1;
                    if (!w_misalign) begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_bp = 1'b1;
                if (bus.req_ready_i) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_bp = !bus.resp_valid_i;
                if (bus.resp_valid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // BU/HU share the low width bits of B/H; unused codes fall back to word
    always_comb begin
        w_strb  = 4'b1111;
        w_wdata = 32'h0;
        if (op_typ_i == c_OP_STORE) begin
            case (width_i[1:0])
                2'd0: begin
                    w_strb  = 4'b0001 << addr_i[1:0];
                    w_wdata = {4{wdata_i[7:0]}};
                end
                2'd1: begin
                    w_strb  = 4'b0011 << addr_i[1:0];
                    w_wdata = {2{wdata_i[15:0]}};
                end
                default: begin
                    w_strb  = 4'b1111;
                    w_wdata = wdata_i;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_back      <= 1'b0;
            r_wb_typ    <= 2'd0;
            r_wb_width  <= 3'd0;
            r_wb_addr   <= 32'h0;
            r_req_addr  <= 32'h0;
            r_req_we    <= 1'b0;
            r_req_strb  <= 4'h0;
            r_req_wdata <= 32'h0;
            r_rdata     <= 32'h0;
            r_exc       <= 1'b0;
        end else begin
            r_back <= w_done;
            r_exc  <= 1'b0;
            if (w_accept) begin
                r_wb_typ    <= op_typ_i;
                r_wb_width  <= width_i;
                r_wb_addr   <= addr_i;
                r_req_addr  <= {addr_i[31:2], 2'b00};
                r_req_we    <= (op_typ_i == c_OP_STORE);
                r_req_strb  <= w_strb;
                r_req_wdata <= w_wdata;
                r_exc       <= w_misalign;
            end
            if (w_done) begin
                r_rdata <= bus.resp_data_i;
                r_exc   <= bus.resp_err_i;
            end
        end
    end

    assign lsu_bp_o        = w_bp;
    assign wb_op_typ_o     = r_wb_typ;
    assign wb_width_o      = r_wb_width;
    assign wb_addr_o       = r_wb_addr;
    assign lsu_rd_data_o   = w_done ? bus.resp_data_i : r_rdata;
    assign lsu_exc_o       = r_exc;
    assign bus.req_valid_o = (r_state == S_REQ);
    assign bus.req_addr_o  = r_req_addr;
    assign bus.req_we_o    = r_req_we;
    assign bus.req_strb_o  = r_req_strb;
    assign bus.req_wdata_o = r_req_wdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus.sv
// tb_lsu_bus: directed load/store vectors with a queue-based scoreboard monitor.
`default_nettype none

module tb_lsu_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_vld_i;
    logic [1:0]  op_typ_i;
    logic [2:0]  width_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        lsu_bp_o;
    logic [1:0]  wb_op_typ_o;
    logic [2:0]  wb_width_o;
    logic [31:0] wb_addr_o;
    logic [31:0] lsu_rd_data_o;
    logic        lsu_exc_o;

    lsu_bus_if bus ();

    lsu_bus dut (
        .clk          (clk),
        .rst          (rst),
        .op_vld_i     (op_vld_i),
        .op_typ_i     (op_typ_i),
        .width_i      (width_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .lsu_bp_o     (lsu_bp_o),
        .wb_op_typ_o  (wb_op_typ_o),
        .wb_width_o   (wb_width_o),
        .wb_addr_o    (wb_addr_o),
        .lsu_rd_data_o(lsu_rd_data_o),
        .lsu_exc_o    (lsu_exc_o),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [68:0] q_req[$];
    logic [31:0] q_rd[$];
    logic [31:0] q_exc[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: checks each bus handshake, consumed response and exception pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_valid_o && bus.req_ready_i) begin
                if (q_req.size() == 0) chk("req_unexpected", 1, 0);
                else chk("req_fields", {bus.req_addr_o, bus.req_we_o, bus.req_wdata_o, bus.req_strb_o},
                         q_req.pop_front());
            end
            if (bus.resp_valid_i && !lsu_bp_o && (q_rd.size() != 0))
                chk("rd_data", lsu_rd_data_o, q_rd.pop_front());
            if (lsu_exc_o) begin
                if (q_exc.size() == 0) chk("exc_unexpected", 1, 0);
                else chk("exc_wb_addr", wb_addr_o, q_exc.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(
        input  logic [1:0]  typ,
        input  logic [2:0]  wid,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] e_addr,
        input  logic        e_we,
        input  logic [31:0] e_wdata,
        input  logic [3:0]  e_strb,
        input  bit          issue,
        input  int          rdy_dly,
        input  int          resp_dly,
        input  logic [31:0] rdata,
        input  logic        err,
        output int          bp_cnt,
        output logic        first_bp
    );
        bit          started = 0;
        bit          done    = 0;
        bit          first   = 1;
        bit          in_resp = 0;
        bit          hs;
        int          seen = 0;
        int          rc   = 0;
        int          cyc  = 0;
        logic [68:0] hold = '0;
        logic [68:0] cur;
        if (issue) begin
            q_req.push_back({e_addr, e_we, e_wdata, e_strb});
            q_rd.push_back(rdata);
        end
        if (!issue || err) q_exc.push_back(addr);
        op_vld_i = 1'b1; op_typ_i = typ; width_i = wid; addr_i = addr; wdata_i = wdata;
        bus.req_ready_i  = (rdy_dly == 0);
        bus.resp_valid_i = 1'b0;
        bus.resp_data_i  = rdata;
        bus.resp_err_i   = err;
        bp_cnt   = 0;
        first_bp = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            if (first) begin first_bp = lsu_bp_o; first = 0; end
            if (lsu_bp_o) begin started = 1; bp_cnt++; end
            else if (started) done = 1;
            hs = 0;
            if (bus.req_valid_o) begin
                cur = {bus.req_addr_o, bus.req_we_o, bus.req_wdata_o, bus.req_strb_o};
                if (seen == 0) hold = cur;
                else chk("req_stable", cur, hold);
                seen++;
                hs = bus.req_ready_i;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (started) op_vld_i = 1'b0;
            bus.req_ready_i = (seen >= rdy_dly) && !hs && !in_resp;
            if (hs) begin in_resp = 1; rc = 0; end
            if (in_resp) begin
                bus.resp_valid_i = (rc == resp_dly) && !done;
                rc++;
            end
            if (done) bus.resp_valid_i = 1'b0;
        end
        chk("op_timeout", done, 1);
    endtask

    int   bp;
    logic fbp;

    initial begin
        rst = 1'b1; op_vld_i = 0; op_typ_i = 0; width_i = 0; addr_i = 0; wdata_i = 0;
        bus.req_ready_i = 0; bus.resp_valid_i = 0; bus.resp_data_i = 0; bus.resp_err_i = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outs", {bus.req_valid_o, bus.req_addr_o, bus.req_we_o, bus.req_strb_o, bus.req_wdata_o,
                           lsu_exc_o, lsu_bp_o, wb_op_typ_o, wb_width_o, wb_addr_o, lsu_rd_data_o}, 0);
        tick();
        rst = 1'b0;
        tick();

        // LOAD W 0x100, response one cycle into RESP
        do_op(2'd1, 3'd2, 32'h100, 32'h0, 32'h100, 1'b0, 32'h0, 4'hF, 1, 0, 1, 32'hDEADBEEF, 1'b0, bp, fbp);
        chk("load_w_bp_cycles", bp, 3);
        @(negedge clk);
        chk("load_w_rd_hold", lsu_rd_data_o, 32'hDEADBEEF);
        chk("load_w_wb", {wb_op_typ_o, wb_width_o, wb_addr_o}, {2'd1, 3'd2, 32'h100});
        tick();

        do_op(2'd2, 3'd0, 32'h203, 32'hA5, 32'h200, 1'b1, 32'hA5A5A5A5, 4'b1000, 1, 0, 0, 32'h0, 1'b0, bp, fbp);
        chk("store_b_bp_cycles", bp, 2);
        tick();

        // ready withheld for four REQ cycles
        do_op(2'd2, 3'd1, 32'h002, 32'h1234BEEF, 32'h0, 1'b1, 32'hBEEFBEEF, 4'b1100, 1, 4, 0, 32'h11111111, 1'b0, bp, fbp);
        chk("store_h_stall_bp_cycles", bp, 6);
        tick();

        do_op(2'd2, 3'd2, 32'h10, 32'hCAFEF00D, 32'h10, 1'b1, 32'hCAFEF00D, 4'hF, 1, 1, 2, 32'h22222222, 1'b0, bp, fbp);
        chk("store_w_bp_cycles", bp, 5);
        tick();

        // bus error on a load
        do_op(2'd1, 3'd0, 32'h7, 32'h0, 32'h4, 1'b0, 32'h0, 4'hF, 1, 0, 0, 32'h55, 1'b1, bp, fbp);
        chk("load_err_bp_cycles", bp, 2);

        // offered in the return-to-IDLE cycle: must wait one cycle
        do_op(2'd1, 3'd5, 32'h40, 32'h0, 32'h40, 1'b0, 32'h0, 4'hF, 1, 0, 0, 32'h77, 1'b0, bp, fbp);
        chk("b2b_first_bp", fbp, 0);
        chk("b2b_bp_cycles", bp, 2);
        chk("b2b_wb", {wb_op_typ_o, wb_width_o}, {2'd1, 3'd5});
        tick();

`ifdef LSU_MISALIGN_TRAP_EN
        do_op(2'd1, 3'd2, 32'h102, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 0, 32'h0, 1'b0, bp, fbp);
        chk("misalign_w_bp_cycles", bp, 1);
        tick();
        do_op(2'd2, 3'd1, 32'h003, 32'hABCD, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 0, 32'h0, 1'b0, bp, fbp);
        chk("misalign_h_bp_cycles", bp, 1);
        tick();
`else
        do_op(2'd1, 3'd2, 32'h102, 32'h0, 32'h100, 1'b0, 32'h0, 4'hF, 1, 0, 0, 32'h99, 1'b0, bp, fbp);
        chk("unaligned_w_bp_cycles", bp, 2);
        tick();
        do_op(2'd2, 3'd1, 32'h003, 32'hABCD, 32'h0, 1'b1, 32'hABCDABCD, 4'b1000, 1, 0, 0, 32'h0, 1'b0, bp, fbp);
        chk("unaligned_h_bp_cycles", bp, 2);
        tick();
`endif

        // reset while waiting in RESP abandons the transaction
        q_req.push_back({32'h300, 1'b0, 32'h0, 4'hF});
        op_vld_i = 1; op_typ_i = 2'd1; width_i = 3'd2; addr_i = 32'h300; bus.req_ready_i = 1;
        @(negedge clk);
        tick();
        op_vld_i = 0;
        @(negedge clk);
        tick();
        bus.req_ready_i = 0;
        @(negedge clk);
        chk("resp_wait_bp", lsu_bp_o, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_outs", {bus.req_valid_o, bus.req_addr_o, bus.req_we_o, bus.req_strb_o, bus.req_wdata_o,
                            lsu_exc_o, lsu_bp_o, wb_op_typ_o, wb_width_o, wb_addr_o, lsu_rd_data_o}, 0);
        tick();
        bus.resp_valid_i = 1; bus.resp_data_i = 32'h12345678; bus.resp_err_i = 1;
        @(negedge clk);
        chk("stale_resp_bypass", {lsu_rd_data_o, lsu_bp_o}, 0);
        tick();
        bus.resp_valid_i = 0;
        @(negedge clk);
        chk("stale_resp_ignored", {lsu_rd_data_o, lsu_exc_o, bus.req_valid_o}, 0);
        tick();

        chk("q_req_drained", q_req.size(), 0);
        chk("q_rd_drained", q_rd.size(), 0);
        chk("q_exc_drained", q_exc.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
